// File: rtl/sv39_ptw.sv
// Sv39 page-table walker: sequences up to three PTE reads over one 64-bit read port
// and returns a zero-extended physical address, or a page fault.
module sv39_ptw #(
   parameter int PADDR_W   = 56,
   parameter int PTE_BYTES = 8
) (
   input  logic        ptw_i_clk,
   input  logic        ptw_i_rst_n,
   input  logic        ptw_i_req_valid,
   output logic        ptw_o_req_ready,
   input  logic [63:0] ptw_i_req_vaddr,
   input  logic [1:0]  ptw_i_req_type,
   input  logic [63:0] ptw_i_satp,
   output logic        ptw_o_mem_valid,
   input  logic        ptw_i_mem_ready,
   output logic [63:0] ptw_o_mem_addr,
   input  logic        ptw_i_mem_rvalid,
   input  logic [63:0] ptw_i_mem_rdata,
   output logic        ptw_o_resp_valid,
   input  logic        ptw_i_resp_ready,
   output logic [63:0] ptw_o_resp_paddr,
   output logic        ptw_o_resp_fault,
   output logic [1:0]  ptw_o_resp_level
);
   localparam int PTE_SHIFT = $clog2(PTE_BYTES);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [38:0]         r_vaddr;
   logic [1:0]          r_type;
   logic [43:0]         r_base_ppn;
   logic [1:0]          r_level;
   logic [PADDR_W-1:0]  r_paddr;
   logic                r_fault;
   logic [1:0]          r_leaf_level;

   logic                w_accept;
   logic                w_bare;
   logic                w_early_fault;
   logic                w_rsp;
   logic [43:0]         w_ppn;
   logic                w_pte_bad;
   logic                w_pointer;
   logic                w_perm_ok;
   logic                w_ad_ok;
   logic                w_align_ok;
   logic                w_descend;
   logic                w_walk_fault;
   logic [8:0]          w_vpn;
   logic [63:0]         w_pte_addr;
   logic [PADDR_W-1:0]  w_leaf_paddr;
   logic                w_unused_bits;

   assign w_accept      = (r_state == S_IDLE) && ptw_i_req_valid;
   assign w_bare        = (ptw_i_satp[63:60] == 4'd0);
   assign w_early_fault = !w_bare && ((ptw_i_satp[63:60] != 4'd8) || (ptw_i_req_type == 2'd3) ||
                          (ptw_i_req_vaddr[63:39] != {25{ptw_i_req_vaddr[38]}}));
   assign w_rsp         = (r_state == S_WAIT) && ptw_i_mem_rvalid;
   assign w_unused_bits = ^{ptw_i_satp[59:44], ptw_i_mem_rdata[63:54], ptw_i_mem_rdata[9:8],
                            ptw_i_mem_rdata[5:4]};

   // PTE decode: V=0, R=1, W=2, X=3, A=6, D=7; U, G and RSW are ignored
   assign w_ppn     = ptw_i_mem_rdata[53:10];
   assign w_pte_bad = !ptw_i_mem_rdata[0] || (!ptw_i_mem_rdata[1] && ptw_i_mem_rdata[2]);
   assign w_pointer = !ptw_i_mem_rdata[1] && !ptw_i_mem_rdata[3];
   assign w_ad_ok   = ptw_i_mem_rdata[6] && ((r_type != 2'd2) || ptw_i_mem_rdata[7]);
   assign w_descend = !w_pte_bad && w_pointer && (r_level != 2'd0);
   assign w_walk_fault = w_pte_bad || (w_pointer && (r_level == 2'd0)) ||
                         (!w_pointer && (!w_perm_ok || !w_ad_ok || !w_align_ok));

   // Leaf checks that depend on access type and level
   always_comb begin
      w_perm_ok    = 1'b0;
      w_align_ok   = 1'b1;
      w_vpn        = r_vaddr[20:12];
      w_leaf_paddr = {w_ppn, r_vaddr[11:0]};
      case (r_type)
         2'd0:    w_perm_ok = ptw_i_mem_rdata[3];
         2'd1:    w_perm_ok = ptw_i_mem_rdata[1];
         2'd2:    w_perm_ok = ptw_i_mem_rdata[2];
         default: w_perm_ok = 1'b0;
      endcase
      case (r_level)
         2'd2: begin
            w_align_ok   = (w_ppn[17:0] == 18'd0);
            w_vpn        = r_vaddr[38:30];
            w_leaf_paddr = {w_ppn[43:18], r_vaddr[29:0]};
         end
         2'd1: begin
            w_align_ok   = (w_ppn[8:0] == 9'd0);
            w_vpn        = r_vaddr[29:21];
            w_leaf_paddr = {w_ppn[43:9], r_vaddr[20:0]};
         end
         default: begin
            w_align_ok   = 1'b1;
            w_vpn        = r_vaddr[20:12];
            w_leaf_paddr = {w_ppn, r_vaddr[11:0]};
         end
      endcase
   end

   assign w_pte_addr = {8'd0, r_base_ppn, 12'd0} +
                       {{(64 - 9 - PTE_SHIFT){1'b0}}, w_vpn, {PTE_SHIFT{1'b0}}};

   // State register
   always_ff @(posedge ptw_i_clk or negedge ptw_i_rst_n) begin
      if (!ptw_i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ptw_i_req_valid) begin
               w_next = (w_bare || w_early_fault) ? S_RESP : S_REQ;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_REQ: begin
            if (ptw_i_mem_ready) w_next = S_WAIT;
            else                 w_next = S_REQ;
         end
         S_WAIT: begin
            if (ptw_i_mem_rvalid) w_next = w_descend ? S_REQ : S_RESP;
            else                  w_next = S_WAIT;
         end
         S_RESP: begin
            if (ptw_i_resp_ready) w_next = S_IDLE;
            else                  w_next = S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Walk context and result registers
   always_ff @(posedge ptw_i_clk or negedge ptw_i_rst_n) begin
      if (!ptw_i_rst_n) begin
         r_vaddr      <= 39'd0;
         r_type       <= 2'd0;
         r_base_ppn   <= 44'd0;
         r_level      <= 2'd0;
         r_paddr      <= {PADDR_W{1'b0}};
         r_fault      <= 1'b0;
         r_leaf_level <= 2'd0;
      end else if (w_accept) begin
         r_vaddr      <= ptw_i_req_vaddr[38:0];
         r_type       <= ptw_i_req_type;
         r_base_ppn   <= ptw_i_satp[43:0];
         r_level      <= 2'd2;
         r_paddr      <= w_bare ? ptw_i_req_vaddr[PADDR_W-1:0] : {PADDR_W{1'b0}};
         r_fault      <= !w_bare && w_early_fault;
         r_leaf_level <= 2'd0;
      end else if (w_rsp && w_descend) begin
         r_level      <= r_level - 2'd1;
         r_base_ppn   <= w_ppn;
      end else if (w_rsp) begin
         r_paddr      <= w_walk_fault ? {PADDR_W{1'b0}} : w_leaf_paddr;
         r_fault      <= w_walk_fault;
         r_leaf_level <= w_walk_fault ? 2'd0 : r_level;
      end else begin
         r_level      <= r_level;
      end
   end

   // Outputs decoded from state; data fields are forced to zero outside their phase
   always_comb begin
      ptw_o_req_ready  = (r_state == S_IDLE);
      ptw_o_mem_valid  = (r_state == S_REQ);
      ptw_o_mem_addr   = (r_state == S_REQ) ? w_pte_addr : 64'd0;
      ptw_o_resp_valid = (r_state == S_RESP);
      if (r_state == S_RESP) begin
         ptw_o_resp_paddr = {{(64 - PADDR_W){1'b0}}, r_paddr};
         ptw_o_resp_fault = r_fault;
         ptw_o_resp_level = r_leaf_level;
      end else begin
         ptw_o_resp_paddr = 64'd0;
         ptw_o_resp_fault = 1'b0;
         ptw_o_resp_level = 2'd0;
      end
   end
endmodule
